// File: rtl/vga_regfile.sv
// vga_regfile: native-side register file for the VGA controller.
// Holds staged control/colour registers that become active only at frame
// boundaries (or immediately while the display is disabled), sticky W1C
// status flags, a frame counter, an interrupt enable mask and the IRQ line.
// Read data is registered and reflects register values before any
// same-cycle update.
module vga_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_write_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_read_i,
    input  logic                  read_en_sync_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  frame_end_i,
    input  logic                  underflow_i,
    output logic                  enable_o,
    output logic                  test_pattern_o,
    output logic [1:0]            pattern_sel_o,
    output logic [11:0]           fg_color_o,
    output logic [11:0]           bg_color_o,
    output logic                  irq_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FG     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BG     = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FCNT   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQEN  = ADDR_WIDTH'(5);

    // Staged (software-visible) registers
    logic [3:0]            ctrl_q,   ctrl_d;
    logic [11:0]           fg_q,     fg_d;
    logic [11:0]           bg_q,     bg_d;
    // Active copies driving the outputs
    logic [3:0]            act_ctrl_q, act_ctrl_d;
    logic [11:0]           act_fg_q,   act_fg_d;
    logic [11:0]           act_bg_q,   act_bg_d;
    // Status, counter, interrupt
    logic [1:0]            status_q, status_d;
    logic [31:0]           fcnt_q,   fcnt_d;
    logic [1:0]            irq_en_q, irq_en_d;
    logic                  irq_q,    irq_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic act_enable;
    logic activate;
    logic counted_frame;
    logic [1:0] w1c_mask;

    assign act_enable    = act_ctrl_q[0];
    // While idle the staged values flow straight through so setup is immediate.
    assign activate      = frame_end_i || !act_enable;
    assign counted_frame = frame_end_i && act_enable;
    assign w1c_mask      = (write_en_i && addr_write_i == ADDR_STATUS) ? data_i[1:0] : 2'b00;

    // Next-state for writes, activation, status, counter and interrupt
    always_comb begin
        ctrl_d     = ctrl_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        irq_en_d   = irq_en_q;
        act_ctrl_d = act_ctrl_q;
        act_fg_d   = act_fg_q;
        act_bg_d   = act_bg_q;
        fcnt_d     = fcnt_q;

        if (write_en_i) begin
            case (addr_write_i)
                ADDR_CTRL:  ctrl_d   = data_i[3:0];
                ADDR_FG:    fg_d     = data_i[11:0];
                ADDR_BG:    bg_d     = data_i[11:0];
                ADDR_IRQEN: irq_en_d = data_i[1:0];
                default:    ;
            endcase
        end

        // Activation copies the staged value as it stood before this cycle's write.
        if (activate) begin
            act_ctrl_d = ctrl_q;
            act_fg_d   = fg_q;
            act_bg_d   = bg_q;
        end

        if (counted_frame) begin
            fcnt_d = fcnt_q + 32'd1;
        end

        // Clear first, then set, so a coincident set wins.
        status_d = (status_q & ~w1c_mask) | {underflow_i, counted_frame};
        irq_d    = |(status_q & irq_en_q);
    end

    // Read mux: samples current register values before same-cycle updates
    always_comb begin
        rdata_d = rdata_q;
        if (read_en_sync_i) begin
            rdata_d = '0;
            case (addr_read_i)
                ADDR_CTRL:   rdata_d[3:0]  = ctrl_q;
                ADDR_FG:     rdata_d[11:0] = fg_q;
                ADDR_BG:     rdata_d[11:0] = bg_q;
                ADDR_STATUS: rdata_d[1:0]  = status_q;
                ADDR_FCNT:   rdata_d[31:0] = fcnt_q;
                ADDR_IRQEN:  rdata_d[1:0]  = irq_en_q;
                default:     rdata_d       = '0;
            endcase
        end
    end

    // Register update with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            ctrl_q     <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            act_ctrl_q <= '0;
            act_fg_q   <= '0;
            act_bg_q   <= '0;
            status_q   <= '0;
            fcnt_q     <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            act_ctrl_q <= act_ctrl_d;
            act_fg_q   <= act_fg_d;
            act_bg_q   <= act_bg_d;
            status_q   <= status_d;
            fcnt_q     <= fcnt_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign data_o         = rdata_q;
    assign enable_o       = act_ctrl_q[0];
    assign test_pattern_o = act_ctrl_q[1];
    assign pattern_sel_o  = act_ctrl_q[3:2];
    assign fg_color_o     = act_fg_q;
    assign bg_color_o     = act_bg_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_vga_regfile.sv
// Testbench for vga_regfile: directed stimulus with a read-data scoreboard.
// Read strobes push the expected value; the monitor pops and compares it
// on the cycle data_o becomes valid.
module tb_vga_regfile;

    localparam int DW = 32;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n_i = 1'b0;
    logic [AW-1:0] addr_write_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          write_en_i = 1'b0;
    logic [AW-1:0] addr_read_i = '0;
    logic          read_en_sync_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          frame_end_i = 1'b0;
    logic          underflow_i = 1'b0;
    logic          enable_o;
    logic          test_pattern_o;
    logic [1:0]    pattern_sel_o;
    logic [11:0]   fg_color_o;
    logic [11:0]   bg_color_o;
    logic          irq_o;

    vga_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n_i),
        .addr_write_i   (addr_write_i),
        .data_i         (data_i),
        .write_en_i     (write_en_i),
        .addr_read_i    (addr_read_i),
        .read_en_sync_i (read_en_sync_i),
        .data_o         (data_o),
        .frame_end_i    (frame_end_i),
        .underflow_i    (underflow_i),
        .enable_o       (enable_o),
        .test_pattern_o (test_pattern_o),
        .pattern_sel_o  (pattern_sel_o),
        .fg_color_o     (fg_color_o),
        .bg_color_o     (bg_color_o),
        .irq_o          (irq_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          rd_fire = 1'b0;

    always @(posedge clk) rd_fire <= read_en_sync_i && arst_n_i;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) check("sb_unexpected_read", 32'd1, 32'd0);
            else check("read_data", data_o, exp_q.pop_front());
        end
    end

    // ---------------- drivers (one call = one cycle) ----------------
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic [DW-1:0] rexp,
                         input logic fe, input logic uf);
        @(negedge clk);
        write_en_i     = we;
        addr_write_i   = wa;
        data_i         = wd;
        read_en_sync_i = re;
        addr_read_i    = ra;
        frame_end_i    = fe;
        underflow_i    = uf;
        if (re) exp_q.push_back(rexp);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        drive(1'b0, '0, '0, 1'b1, a, e, 1'b0, 1'b0);
    endtask

    task automatic frame_pulse();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n_i = 1'b0;
        repeat (3) idle();
        @(negedge clk);
        arst_n_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // Reset state
        check("rst_enable", DW'(enable_o), 0);
        check("rst_tp", DW'(test_pattern_o), 0);
        check("rst_psel", DW'(pattern_sel_o), 0);
        check("rst_fg", DW'(fg_color_o), 0);
        check("rst_bg", DW'(bg_color_o), 0);
        check("rst_irq", DW'(irq_o), 0);
        check("rst_data", data_o, 0);
        for (int a = 0; a < 6; a++) rd(AW'(a), 32'h0);

        // Idle: configuration is immediate (two cycles after the write)
        wr(4'h1, 32'h0000_0ABC);
        idle();
        check("fg_idle_n1", DW'(fg_color_o), 32'h0);
        idle();
        check("fg_idle_n2", DW'(fg_color_o), 32'hABC);
        rd(4'h1, 32'h0000_0ABC);
        wr(4'h0, 32'h1);
        idle();
        check("en_idle_n1", DW'(enable_o), 32'h0);
        idle();
        check("en_idle_n2", DW'(enable_o), 32'h1);

        // Enabled: staged colour waits for frame end
        wr(4'h2, 32'h123);
        repeat (3) idle();
        check("bg_wait", DW'(bg_color_o), 32'h0);
        frame_pulse();
        check("bg_at_fe", DW'(bg_color_o), 32'h0);
        idle();
        check("bg_after_fe", DW'(bg_color_o), 32'h123);
        // Write coincident with frame end: old staged value is activated
        drive(1'b1, 4'h2, 32'h456, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();
        check("bg_coincident", DW'(bg_color_o), 32'h123);
        frame_pulse();
        idle();
        check("bg_next_fe", DW'(bg_color_o), 32'h456);
        rd(4'h4, 32'd3);

        // Interrupts: underflow with IRQ_EN=2
        wr(4'h3, 32'h1);           // clear frame_done
        wr(4'h5, 32'h2);
        rd(4'h5, 32'h2);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle();
        check("irq_lag", DW'(irq_o), 32'h0);
        idle();
        check("irq_set", DW'(irq_o), 32'h1);
        rd(4'h3, 32'h2);
        wr(4'h3, 32'h2);
        rd(4'h3, 32'h0);
        check("irq_still", DW'(irq_o), 32'h1);
        idle();
        check("irq_clr", DW'(irq_o), 32'h0);
        // Set wins over coincident clear
        drive(1'b1, 4'h3, 32'h2, 1'b0, '0, '0, 1'b0, 1'b1);
        rd(4'h3, 32'h2);
        idle();
        check("irq_set_wins", DW'(irq_o), 32'h1);
        wr(4'h3, 32'h0);           // writing 0 leaves it set
        rd(4'h3, 32'h2);

        // Frame counter: 5 enabled frames, 3 disabled frames
        do_reset();
        rd(4'h4, 32'h0);
        wr(4'h0, 32'h1);
        idle();
        idle();
        check("en_fcnt", DW'(enable_o), 32'h1);
        repeat (4) frame_pulse();
        wr(4'h0, 32'h0);
        frame_pulse();             // 5th counted frame, activates disable
        idle();
        check("dis_after_fe", DW'(enable_o), 32'h0);
        repeat (3) frame_pulse();
        idle();
        rd(4'h4, 32'd5);
        rd(4'h3, 32'h1);
        wr(4'h4, 32'hFFFF_FFFF);
        rd(4'h4, 32'd5);
        wr(4'h9, 32'h1234_5678);
        rd(4'h9, 32'h0);
        for (int a = 0; a < 6; a++) begin
            logic [DW-1:0] e;
            e = (a == 3) ? 32'h1 : ((a == 4) ? 32'd5 : 32'h0);
            rd(AW'(a), e);
        end

        // Same-cycle write and read of one address
        wr(4'h1, 32'h111);
        drive(1'b1, 4'h1, 32'h222, 1'b1, 4'h1, 32'h111, 1'b0, 1'b0);
        rd(4'h1, 32'h222);
        idle();
        idle();
        check("data_hold", data_o, 32'h222);

        // Unimplemented bits are discarded; random colour round-trips
        wr(4'h0, 32'hFFFF_FFF6);
        rd(4'h0, 32'h6);
        idle();
        idle();
        check("tp_out", DW'(test_pattern_o), 32'h1);
        check("psel_out", DW'(pattern_sel_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] v;
            v = $urandom_range(0, 32'hFFFF_FFFF);
            wr(4'h2, v);
            rd(4'h2, {20'h0, v[11:0]});
        end

        idle();
        idle();
        check("sb_drain", DW'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
